// File: rtl/cmp_ctrl_pkg.sv
// Shared types and sizing for the shared-comparator arbiter.
// The FSM encoding, default dimensions and requester-ID width derivation live here.
package cmp_ctrl_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      COMPARE = 1'b1
   } state_t;

   typedef struct packed {
      logic gt;
      logic lt;
      logic eq;
   } cmp_flags_t;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_WIDTH   = 4;

   function automatic int unsigned id_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Request/grant/result bundle between the client blocks and the shared comparator.
interface cmp_share_arbiter_if
   import cmp_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned WIDTH   = DEF_WIDTH
) ();
   localparam int unsigned ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] a_in;
   logic [NUM_REQ*WIDTH-1:0] b_in;
   logic [NUM_REQ-1:0]       gnt;
   logic                     busy;
   logic                     res_valid;
   logic [ID_W-1:0]          res_id;
   logic                     res_gt;
   logic                     res_lt;
   logic                     res_eq;

   modport master (
      output req, a_in, b_in,
      input  gnt, busy, res_valid, res_id, res_gt, res_lt, res_eq
   );

   modport slave (
      input  req, a_in, b_in,
      output gnt, busy, res_valid, res_id, res_gt, res_lt, res_eq
   );
endinterface

// File: rtl/cmp_core.sv
// Unsigned full-width magnitude comparator; purely combinational.
module cmp_core #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt,
   output logic             lt,
   output logic             eq
);
   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);
endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NUM_REQ requesters.
// Grant and operand latch in IDLE, tagged result one cycle later in COMPARE.
module cmp_share_arbiter
   import cmp_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned WIDTH   = DEF_WIDTH
) (
   input logic                clk,
   input logic                rst_n,
   cmp_share_arbiter_if.slave bus
);
   localparam int unsigned ID_W = id_width(NUM_REQ);

   state_t             state, state_d;
   logic [ID_W-1:0]    last_id, last_id_d;
   logic [ID_W-1:0]    cur_id, cur_id_d;
   logic [WIDTH-1:0]   op_a, op_a_d;
   logic [WIDTH-1:0]   op_b, op_b_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               res_valid_q, res_valid_d;
   logic [ID_W-1:0]    res_id_q, res_id_d;
   cmp_flags_t         res_q, res_d;

   logic [WIDTH-1:0]   a_arr [NUM_REQ];
   logic [WIDTH-1:0]   b_arr [NUM_REQ];
   logic               found;
   logic [ID_W-1:0]    pick;
   logic [ID_W-1:0]    cand;
   logic               core_gt, core_lt, core_eq;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign a_arr[i] = bus.a_in[i*WIDTH +: WIDTH];
      assign b_arr[i] = bus.b_in[i*WIDTH +: WIDTH];
   end

   cmp_core #(.WIDTH(WIDTH)) u_core (
      .a  (op_a),
      .b  (op_b),
      .gt (core_gt),
      .lt (core_lt),
      .eq (core_eq)
   );

   // Rotating priority: the requester after the last grant is checked first.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((32'(last_id) + k) % NUM_REQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d     = state;
      last_id_d   = last_id;
      cur_id_d    = cur_id;
      op_a_d      = op_a;
      op_b_d      = op_b;
      gnt_d       = '0;
      res_valid_d = 1'b0;
      res_id_d    = res_id_q;
      res_d       = res_q;
      case (state)
         IDLE: begin
            if (found) begin
               gnt_d     = NUM_REQ'(1) << pick;
               op_a_d    = a_arr[pick];
               op_b_d    = b_arr[pick];
               cur_id_d  = pick;
               last_id_d = pick;
               state_d   = COMPARE;
            end
         end
         COMPARE: begin
            res_valid_d = 1'b1;
            res_id_d    = cur_id;
            res_d       = '{gt: core_gt, lt: core_lt, eq: core_eq};
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_id     <= ID_W'(NUM_REQ - 1);
         cur_id      <= '0;
         op_a        <= '0;
         op_b        <= '0;
         gnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_q       <= '0;
      end else begin
         state       <= state_d;
         last_id     <= last_id_d;
         cur_id      <= cur_id_d;
         op_a        <= op_a_d;
         op_b        <= op_b_d;
         gnt_q       <= gnt_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_q       <= res_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.busy      = (state == COMPARE);
   assign bus.res_valid = res_valid_q;
   assign bus.res_id    = res_id_q;
   assign bus.res_gt    = res_q.gt;
   assign bus.res_lt    = res_q.lt;
   assign bus.res_eq    = res_q.eq;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: directed scenarios plus randomized
// transactions against a round-robin / arithmetic reference model.
module tb_cmp_share_arbiter;
   import cmp_ctrl_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 4;
   localparam int unsigned IW = $clog2(N);

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   passed = 0;
   int   last_ptr;

   cmp_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

   cmp_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Spec-level round-robin: first set request after the last granted index.
   function automatic int rr_pick(input int last, input logic [N-1:0] r);
      for (int k = 1; k <= int'(N); k++) begin
         int i;
         i = (last + k) % int'(N);
         if (r[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [2:0] cmp_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2:0] f;
      f[2] = (int'(a) > int'(b));
      f[1] = (int'(a) < int'(b));
      f[0] = (int'(a) == int'(b));
      return f;
   endfunction

   function automatic logic [W-1:0] slice(input logic [N*W-1:0] v, input int i);
      return v[i*W +: W];
   endfunction

   task automatic test_reset();
      logic [N+IW+4:0] obs;
      rst_n    = 1'b1;
      bus.req  = '1;
      bus.a_in = 16'h3A5C;
      bus.b_in = 16'h1F27;
      #2 rst_n = 1'b0;
      #1;
      obs = {bus.gnt, bus.busy, bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq};
      checks++;
      if (obs !== '0) $display("FAIL reset_outputs: got %b want 0", obs);
      else passed++;
      step();
      checks++;
      if ({bus.gnt, bus.busy, bus.res_valid} !== '0)
         $display("FAIL reset_hold: got %b want 0", {bus.gnt, bus.busy, bus.res_valid});
      else passed++;
      rst_n = 1'b1;
      step();
      checks++;
      if ({bus.gnt, bus.busy, bus.res_valid} !== {4'b0001, 1'b1, 1'b0})
         $display("FAIL reset_first_gnt: got %b want 000110", {bus.gnt, bus.busy, bus.res_valid});
      else passed++;
      bus.req = '0;
      step();
      checks++;
      if ({bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq} !== {1'b1, 2'd0, 3'b001 << 2})
         $display("FAIL reset_first_res: got %b want 1_00_100",
                  {bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq});
      else passed++;
      last_ptr = 0;
   endtask

   task automatic test_single_gt();
      bus.a_in[0 +: W] = 4'b1000;
      bus.b_in[0 +: W] = 4'b0000;
      bus.req = 4'b0001;
      step();
      checks++;
      if ({bus.gnt, bus.busy, bus.res_valid} !== {4'b0001, 1'b1, 1'b0})
         $display("FAIL single_gnt: got %b want 000110", {bus.gnt, bus.busy, bus.res_valid});
      else passed++;
      bus.req = '0;
      step();
      checks++;
      if ({bus.gnt, bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq} !== {4'b0000, 1'b1, 2'd0, 3'b100})
         $display("FAIL single_res: got %b want 0000_1_00_100",
                  {bus.gnt, bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq});
      else passed++;
      step();
      checks++;
      if (bus.res_valid !== 1'b0) $display("FAIL single_pulse: res_valid got %b want 0", bus.res_valid);
      else passed++;
      last_ptr = 0;
   endtask

   task automatic test_eq_lt();
      bus.a_in[2*W +: W] = 4'b1111;
      bus.b_in[2*W +: W] = 4'b1111;
      bus.req = 4'b0100;
      step();
      bus.req = '0;
      step();
      checks++;
      if ({bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq} !== {1'b1, 2'd2, 3'b001})
         $display("FAIL eq_res: got %b want 1_10_001",
                  {bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq});
      else passed++;
      bus.a_in[2*W +: W] = 4'b0000;
      bus.req = 4'b0100;
      step();
      bus.req = '0;
      step();
      checks++;
      if ({bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq} !== {1'b1, 2'd2, 3'b010})
         $display("FAIL lt_res: got %b want 1_10_010",
                  {bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq});
      else passed++;
      last_ptr = 2;
   endtask

   task automatic test_round_robin();
      logic [N-1:0] oh;
      int p;
      for (int i = 0; i < int'(N); i++) begin
         bus.a_in[i*W +: W] = W'(i * 3 + 1);
         bus.b_in[i*W +: W] = W'(7);
      end
      bus.req = '1;
      for (int n = 0; n < 5; n++) begin
         p = rr_pick(last_ptr, bus.req);
         last_ptr = p;
         oh = N'(1) << p;
         step();
         checks++;
         if ({bus.gnt, bus.busy, bus.res_valid} !== {oh, 1'b1, 1'b0})
            $display("FAIL rr_gnt%0d: got %b want %b", n, {bus.gnt, bus.busy, bus.res_valid}, {oh, 2'b10});
         else passed++;
         step();
         checks++;
         if ({bus.gnt, bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq} !==
             {4'b0000, 1'b1, IW'(p), cmp_ref(slice(bus.a_in, p), slice(bus.b_in, p))})
            $display("FAIL rr_res%0d: got %b want id %0d", n,
                     {bus.gnt, bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq}, p);
         else passed++;
      end
      bus.req = '0;
   endtask

   task automatic test_pair();
      bus.req = 4'b0010;
      step();
      checks++;
      if (bus.gnt !== 4'b0010) $display("FAIL pair_first: gnt got %b want 0010", bus.gnt);
      else passed++;
      bus.req = '0;
      step();
      bus.req = 4'b1010;
      step();
      checks++;
      if (bus.gnt !== 4'b1000) $display("FAIL pair_second: gnt got %b want 1000", bus.gnt);
      else passed++;
      step();
      checks++;
      if ({bus.res_valid, bus.res_id} !== {1'b1, 2'd3})
         $display("FAIL pair_res3: got %b want 1_11", {bus.res_valid, bus.res_id});
      else passed++;
      step();
      checks++;
      if (bus.gnt !== 4'b0010) $display("FAIL pair_third: gnt got %b want 0010", bus.gnt);
      else passed++;
      bus.req = '0;
      step();
      checks++;
      if ({bus.res_valid, bus.res_id} !== {1'b1, 2'd1})
         $display("FAIL pair_res1: got %b want 1_01", {bus.res_valid, bus.res_id});
      else passed++;
      last_ptr = 1;
   endtask

   task automatic test_reset_mid();
      bus.req = 4'b0100;
      step();
      checks++;
      if ({bus.gnt, bus.busy} !== {4'b0100, 1'b1})
         $display("FAIL mid_gnt: got %b want 01001", {bus.gnt, bus.busy});
      else passed++;
      bus.req = '0;
      rst_n = 1'b0;
      step();
      checks++;
      if ({bus.gnt, bus.busy, bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq} !== '0)
         $display("FAIL mid_discard: got %b want 0",
                  {bus.gnt, bus.busy, bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq});
      else passed++;
      rst_n = 1'b1;
      bus.req = '1;
      step();
      checks++;
      if (bus.gnt !== 4'b0001) $display("FAIL mid_restart: gnt got %b want 0001", bus.gnt);
      else passed++;
      bus.req = '0;
      step();
      checks++;
      if ({bus.res_valid, bus.res_id} !== {1'b1, 2'd0})
         $display("FAIL mid_res: got %b want 1_00", {bus.res_valid, bus.res_id});
      else passed++;
      last_ptr = 0;
   endtask

   task automatic test_capture();
      bus.a_in[0 +: W] = 4'b0001;
      bus.b_in[0 +: W] = 4'b1000;
      bus.req = 4'b0001;
      step();
      bus.req = '0;
      bus.a_in[0 +: W] = 4'b1110;
      step();
      checks++;
      if ({bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq} !== {1'b1, 2'd0, 3'b010})
         $display("FAIL capture_res: got %b want 1_00_010",
                  {bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq});
      else passed++;
      last_ptr = 0;
   endtask

   task automatic test_random();
      logic [N-1:0]   r;
      logic [N-1:0]   oh;
      logic [N*W-1:0] a0, b0;
      int p;
      for (int n = 0; n < 40; n++) begin
         r  = N'($urandom_range(0, (1 << N) - 1));
         a0 = (N*W)'($urandom);
         b0 = (N*W)'($urandom);
         if (n % 5 == 0) b0 = a0;
         bus.a_in = a0;
         bus.b_in = b0;
         bus.req  = r;
         p = rr_pick(last_ptr, r);
         step();
         if (p < 0) begin
            checks++;
            if ({bus.gnt, bus.busy, bus.res_valid} !== '0)
               $display("FAIL rand_idle%0d: got %b want 0", n, {bus.gnt, bus.busy, bus.res_valid});
            else passed++;
         end else begin
            last_ptr = p;
            oh = N'(1) << p;
            checks++;
            if ({bus.gnt, bus.busy, bus.res_valid} !== {oh, 1'b1, 1'b0})
               $display("FAIL rand_gnt%0d: got %b want %b", n, {bus.gnt, bus.busy, bus.res_valid}, {oh, 2'b10});
            else passed++;
            bus.req  = '0;
            bus.a_in = (N*W)'($urandom);
            step();
            checks++;
            if ({bus.gnt, bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq} !==
                {4'b0000, 1'b1, IW'(p), cmp_ref(slice(a0, p), slice(b0, p))})
               $display("FAIL rand_res%0d: got %b want id %0d flags %b", n,
                        {bus.gnt, bus.res_valid, bus.res_id, bus.res_gt, bus.res_lt, bus.res_eq},
                        p, cmp_ref(slice(a0, p), slice(b0, p)));
            else passed++;
         end
      end
      bus.req = '0;
   endtask

   initial begin
      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;
      test_reset();
      test_single_gt();
      test_eq_lt();
      test_round_robin();
      test_pair();
      test_reset_mid();
      test_capture();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
